// File: rtl/lsu_dmem_port.sv
// ---------------------------------------------------------------------------
// lsu_dmem_port
// Load/store unit front end for a single-ported, word-organised data memory.
// Takes one CPU access at a time. It checks the access for alignment and
// range, then performs one of the following:
//   - a word load;
//   - a word store;
//   - a byte/halfword store, done as a read-modify-write of the containing
//     word.
// Sub-word loads are right-aligned and zero- or sign-extended.
//
// Ports
//   clk         rising-edge system clock
//   rst_n       asynchronous active-low reset
//   cpu_req     access request, sampled only while idle
//   cpu_we      1 = store, 0 = load
//   cpu_size    00 byte, 01 halfword, 10 word, 11 reserved (error)
//   cpu_signed  sign-extend sub-word loads
//   cpu_addr    18-bit byte address
//   cpu_wdata   right-aligned store data
//   cpu_rdata   registered load result, held until the next load completes
//   cpu_ack     one-cycle completion pulse
//   cpu_err     error flag, only meaningful with cpu_ack
//   cpu_busy    high whenever a transaction is in flight
//   mem_a       dmem word address (0 when not accessing)
//   mem_rd      dmem combinational read data
//   mem_wd      dmem write data
//   mem_we      dmem write enable, committed on the next rising clk
// ---------------------------------------------------------------------------
module lsu_dmem_port #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [1:0]        cpu_size,
   input  logic              cpu_signed,
   input  logic [17:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_err,
   output logic              cpu_busy,
   output logic [15:0]       mem_a,
   input  logic [DATA_W-1:0] mem_rd,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_WRITE  = 3'd2;
   localparam logic [2:0] S_RMW_RD = 3'd3;
   localparam logic [2:0] S_RMW_WR = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [DATA_W-1:0] BYTE_M = {{(DATA_W-8){1'b0}}, 8'hFF};
   localparam logic [DATA_W-1:0] HALF_M = {{(DATA_W-16){1'b0}}, 16'hFFFF};

   logic [2:0]        state_q, state_d;
   logic [1:0]        size_q;
   logic              signed_q;
   logic [17:0]       addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;
   logic [DATA_W-1:0] rmw_q;
   logic [DATA_W-1:0] rdata_q;

   logic              reqErr;
   logic [4:0]        byteShift;
   logic [4:0]        halfShift;
   logic [7:0]        loadByte;
   logic [15:0]       loadHalf;
   logic [DATA_W-1:0] loadVal;
   logic [DATA_W-1:0] laneMask;
   logic [DATA_W-1:0] mergedWd;
   logic              accessState;

   // Error classification is evaluated on the live request inputs.
   // The IDLE->RESP branch must be chosen in the accept cycle itself.
   // The range check is done at 32 bits so that a DEPTH of 65536 still
   // compares correctly.
   always_comb begin
      reqErr = 1'b0;
      if (cpu_size == 2'b11) begin
         reqErr = 1'b1;
      end
      if ((cpu_size == SZ_HALF) && cpu_addr[0]) begin
         reqErr = 1'b1;
      end
      if ((cpu_size == SZ_WORD) && (cpu_addr[1:0] != 2'b00)) begin
         reqErr = 1'b1;
      end
      if ({16'b0, cpu_addr[17:2]} >= DEPTH) begin
         reqErr = 1'b1;
      end
   end

   // Lane selection for loads and read-modify-write merging.
   // Byte lanes are little-endian. A halfword is selected by addr bit 1
   // alone, because only even offsets ever reach the datapath.
   always_comb begin
      byteShift = {addr_q[1:0], 3'b000};
      halfShift = {addr_q[1], 4'b0000};
      loadByte  = mem_rd[byteShift +: 8];
      loadHalf  = mem_rd[halfShift +: 16];
      case (size_q)
         SZ_BYTE: loadVal = {{(DATA_W-8){signed_q & loadByte[7]}}, loadByte};
         SZ_HALF: loadVal = {{(DATA_W-16){signed_q & loadHalf[15]}}, loadHalf};
         default: loadVal = mem_rd;
      endcase
      laneMask = (size_q == SZ_BYTE) ? (BYTE_M << byteShift) : (HALF_M << byteShift);
      mergedWd = (rmw_q & ~laneMask) | ((wdata_q << byteShift) & laneMask);
   end

   // Next-state logic.
   // A request is routed straight to its access path. Word stores skip the
   // read because they overwrite every lane.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               if (reqErr) begin
                  state_d = S_RESP;
               end else if (!cpu_we) begin
                  state_d = S_LOAD;
               end else if (cpu_size == SZ_WORD) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_RMW_RD;
               end
            end
         end
         S_LOAD:   state_d = S_RESP;
         S_WRITE:  state_d = S_RESP;
         S_RMW_RD: state_d = S_RMW_WR;
         S_RMW_WR: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State and request registers.
   // The request fields are captured only when idle, so a cpu_req raised
   // while busy has no effect. The load result register only changes at
   // the end of LOAD, so it holds through stores and errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         rmw_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == S_IDLE) && cpu_req) begin
            size_q   <= cpu_size;
            signed_q <= cpu_signed;
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            err_q    <= reqErr;
         end
         if (state_q == S_RMW_RD) begin
            rmw_q <= mem_rd;
         end
         if (state_q == S_LOAD) begin
            rdata_q <= loadVal;
         end
      end
   end

   // Outputs are decoded purely from the state register.
   // An asynchronous reset therefore drops mem_we and the other strobes
   // immediately, without waiting for a clock edge.
   always_comb begin
      accessState = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                    (state_q == S_RMW_RD) || (state_q == S_RMW_WR);
      cpu_busy  = (state_q != S_IDLE);
      cpu_ack   = (state_q == S_RESP);
      cpu_err   = (state_q == S_RESP) && err_q;
      cpu_rdata = rdata_q;
      mem_a     = accessState ? addr_q[17:2] : 16'h0000;
      mem_we    = (state_q == S_WRITE) || (state_q == S_RMW_WR);
      mem_wd    = '0;
      if (state_q == S_WRITE) begin
         mem_wd = wdata_q;
      end else if (state_q == S_RMW_WR) begin
         mem_wd = mergedWd;
      end
   end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// ---------------------------------------------------------------------------
// tb_lsu_dmem_port
// Bench for lsu_dmem_port with a behavioural word memory attached to the
// dmem port. Expected results come from a word-array reference model and
// plain shift/mask arithmetic on byte offsets.
// ---------------------------------------------------------------------------
module tb_lsu_dmem_port;

   localparam int DEPTH = 1024;
   localparam int NREF  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [1:0]  cpu_size = 2'b00;
   logic        cpu_signed = 1'b0;
   logic [17:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;
   logic        cpu_err;
   logic        cpu_busy;
   logic [15:0] mem_a;
   logic [31:0] mem_rd;
   logic [31:0] mem_wd;
   logic        mem_we;

   logic [31:0] dmem [DEPTH];
   logic        preEn = 1'b0;
   logic [9:0]  preIdx = '0;
   logic [31:0] preData = '0;

   logic [31:0] refMem [NREF];
   logic [31:0] lastRd;
   int          compared = 0;
   int          mismatched = 0;

   lsu_dmem_port #(.DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_size(cpu_size), .cpu_signed(cpu_signed), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .cpu_err(cpu_err), .cpu_busy(cpu_busy), .mem_a(mem_a), .mem_rd(mem_rd),
      .mem_wd(mem_wd), .mem_we(mem_we)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Behavioural dmem: combinational read, write committed on the rising edge.
   // The bench also preloads words through a backdoor port.
   assign mem_rd = (mem_a < 16'(DEPTH)) ? dmem[mem_a[9:0]] : 32'hDEADBEEF;

   always @(posedge clk) begin
      if (preEn) dmem[preIdx] <= preData;
      else if (mem_we) dmem[mem_a[9:0]] <= mem_wd;
   end

   // Reference rules for access legality and lane handling.
   function automatic logic modelErr(input logic [1:0] sz, input logic [17:0] a);
      int idx;
      idx = int'(a) / 4;
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
             (sz == 2'd2 && (a % 4) != 0) || (idx >= DEPTH);
   endfunction

   function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input int off);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (w >> (8 * off)) & 32'hFF;
         if (sg && v >= 32'h80) v = v + 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
         v = (w >> (8 * off)) & 32'hFFFF;
         if (sg && v >= 32'h8000) v = v + 32'hFFFF0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] modelStore(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input int off);
      logic [31:0] m;
      if (sz == 2'd2) return d;
      m = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
      return (w & ~m) | ((d << (8 * off)) & m);
   endfunction

   // Backdoor write of one dmem word. The write lands while the DUT is idle.
   task automatic preload(input int idx, input logic [31:0] d);
      @(negedge clk);
      preEn = 1'b1; preIdx = idx[9:0]; preData = d;
      @(negedge clk);
      preEn = 1'b0;
   endtask

   // Drive one request for a single cycle and record what the port does.
   // Cycle numbers count from the accept cycle, which is cycle 0.
   task automatic issue(input bit align, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [17:0] a, input logic [31:0] wd,
                        output int ackCyc, output logic errS, output logic [31:0] rdS,
                        output int weCnt, output int weCyc, output logic [31:0] wdS,
                        output logic [15:0] aFirst, output logic [15:0] aResp,
                        output int errNoAck);
      if (align) @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_signed = sg;
      cpu_addr = a; cpu_wdata = wd;
      ackCyc = -1; errS = 1'b0; rdS = '0; weCnt = 0; weCyc = -1; wdS = '0;
      aFirst = '0; aResp = '0; errNoAck = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         cpu_req = 1'b0;
         if (c == 1) aFirst = mem_a;
         if (mem_we) begin weCnt++; weCyc = c; wdS = mem_wd; end
         if (!cpu_ack && cpu_err) errNoAck++;
         if (cpu_ack) begin
            ackCyc = c; errS = cpu_err; rdS = cpu_rdata; aResp = mem_a;
            break;
         end
      end
   endtask

   // Reset values, then release reset at a negedge.
   task automatic test_reset();
      #12;
      compared++; if (cpu_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_rdata: got %h want 0", cpu_rdata); end
      compared++; if (cpu_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_ack: got %b want 0", cpu_ack); end
      compared++; if (cpu_err !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_err: got %b want 0", cpu_err); end
      compared++; if (cpu_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b want 0", cpu_busy); end
      compared++; if (mem_a !== 16'h0) begin mismatched++; $display("[TB] FAIL rst_mem_a: got %h want 0", mem_a); end
      compared++; if (mem_wd !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_mem_wd: got %h want 0", mem_wd); end
      compared++; if (mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mem_we: got %b want 0", mem_we); end
      @(negedge clk);
      rst_n = 1'b1;
      lastRd = 32'h0;
   endtask

   // Fixed scenarios with literal expected values.
   task automatic test_directed();
      int ac, wc, wy, ena; logic e; logic [31:0] rd, wd; logic [15:0] af, ar;
      preload(0, 32'h070d0001);
      issue(1, 0, 2'd2, 0, 18'h0, 32'h0, ac, e, rd, wc, wy, wd, af, ar, ena);
      compared++; if (ac !== 2) begin mismatched++; $display("[TB] FAIL w0_ack_cycle: got %0d want 2", ac); end
      compared++; if (rd !== 32'h070d0001) begin mismatched++; $display("[TB] FAIL w0_rdata: got %h want 070d0001", rd); end
      compared++; if (e !== 1'b0) begin mismatched++; $display("[TB] FAIL w0_err: got %b want 0", e); end

      preload(2, 32'h01020104);
      preload(3, 32'h80060203);
      issue(1, 0, 2'd0, 1, 18'h0B, 32'h0, ac, e, rd, wc, wy, wd, af, ar, ena);
      compared++; if (rd !== 32'h00000001) begin mismatched++; $display("[TB] FAIL sb_load: got %h want 00000001", rd); end
      issue(1, 0, 2'd1, 1, 18'h0E, 32'h0, ac, e, rd, wc, wy, wd, af, ar, ena);
      compared++; if (rd !== 32'hffff8006) begin mismatched++; $display("[TB] FAIL sh_load: got %h want ffff8006", rd); end
      lastRd = 32'hffff8006;

      preload(1, 32'h00020003);
      issue(1, 1, 2'd0, 0, 18'h05, 32'h000000AA, ac, e, rd, wc, wy, wd, af, ar, ena);
      compared++; if (wc !== 1 || wy !== 2) begin mismatched++; $display("[TB] FAIL sb_store_we: got count %0d cycle %0d want 1 at 2", wc, wy); end
      compared++; if (wd !== 32'h0002AA03) begin mismatched++; $display("[TB] FAIL sb_store_wd: got %h want 0002aa03", wd); end
      compared++; if (ac !== 3) begin mismatched++; $display("[TB] FAIL sb_store_ack: got %0d want 3", ac); end
      compared++; if (dmem[1] !== 32'h0002AA03) begin mismatched++; $display("[TB] FAIL sb_store_mem: got %h want 0002aa03", dmem[1]); end

      issue(1, 0, 2'd1, 0, 18'h03, 32'h0, ac, e, rd, wc, wy, wd, af, ar, ena);
      compared++; if (ac !== 1 || e !== 1'b1 || wc !== 0) begin mismatched++; $display("[TB] FAIL err_misalign: got ack %0d err %b we %0d want 1 1 0", ac, e, wc); end
      compared++; if (rd !== lastRd) begin mismatched++; $display("[TB] FAIL err_rdata_hold: got %h want %h", rd, lastRd); end
      issue(1, 0, 2'd2, 0, 18'(DEPTH * 4), 32'h0, ac, e, rd, wc, wy, wd, af, ar, ena);
      compared++; if (ac !== 1 || e !== 1'b1 || wc !== 0) begin mismatched++; $display("[TB] FAIL err_range: got ack %0d err %b we %0d want 1 1 0", ac, e, wc); end
   endtask

   // Random accesses over a 16-word window, with occasional out-of-range
   // addresses.
   task automatic test_random();
      int ac, wc, wy, ena, idx, off, lat; logic e, we, sg, expE; logic [1:0] sz;
      logic [31:0] rd, wd, d, nw; logic [15:0] af, ar, idx16; logic [17:0] a;
      for (int i = 0; i < NREF; i++) begin
         refMem[i] = $urandom;
         preload(i, refMem[i]);
      end
      for (int t = 0; t < 200; t++) begin
         we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
         sg = 1'($urandom_range(0, 1)); off = $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) idx = DEPTH + $urandom_range(0, 65535 - DEPTH);
         else idx = $urandom_range(0, NREF - 1);
         if ($urandom_range(0, 1) == 1) begin
            if (sz == 2'd2) off = 0;
            else if (sz == 2'd1) off = off & 2;
         end
         idx16 = 16'(idx); a = {idx16, 2'(off)}; d = $urandom;
         issue(1, we, sz, sg, a, d, ac, e, rd, wc, wy, wd, af, ar, ena);
         expE = modelErr(sz, a);
         lat = expE ? 1 : (!we || sz == 2'd2) ? 2 : 3;
         nw = '0;
         if (!expE && !we) lastRd = modelLoad(refMem[idx], sz, sg, off);
         if (!expE && we) begin nw = modelStore(refMem[idx], d, sz, off); refMem[idx] = nw; end
         compared++; if (ac !== lat) begin mismatched++; $display("[TB] FAIL rnd%0d_ack_cycle: got %0d want %0d", t, ac, lat); end
         compared++; if (e !== expE) begin mismatched++; $display("[TB] FAIL rnd%0d_err: got %b want %b", t, e, expE); end
         compared++; if (rd !== lastRd) begin mismatched++; $display("[TB] FAIL rnd%0d_rdata: got %h want %h", t, rd, lastRd); end
         compared++; if (wc !== ((!expE && we) ? 1 : 0)) begin mismatched++; $display("[TB] FAIL rnd%0d_we_count: got %0d", t, wc); end
         compared++; if (af !== (expE ? 16'h0 : idx16) || ar !== 16'h0) begin mismatched++; $display("[TB] FAIL rnd%0d_mem_a: got %h/%h want %h/0", t, af, ar, expE ? 16'h0 : idx16); end
         compared++; if (ena !== 0) begin mismatched++; $display("[TB] FAIL rnd%0d_err_without_ack: got %0d want 0", t, ena); end
         if (!expE && we) begin
            compared++; if (wd !== nw || wy !== lat - 1) begin mismatched++; $display("[TB] FAIL rnd%0d_wd: got %h at %0d want %h at %0d", t, wd, wy, nw, lat - 1); end
            compared++; if (dmem[idx] !== nw) begin mismatched++; $display("[TB] FAIL rnd%0d_mem: got %h want %h", t, dmem[idx], nw); end
         end
      end
      for (int i = 0; i < NREF; i++) begin
         compared++; if (dmem[i] !== refMem[i]) begin mismatched++; $display("[TB] FAIL final_mem%0d: got %h want %h", i, dmem[i], refMem[i]); end
      end
   endtask

   // cpu_req is held for five cycles. Requests seen while busy must be dropped.
   task automatic test_back_to_back();
      int nAck, firstAck, secondAck;
      nAck = 0; firstAck = -1; secondAck = -1;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_signed = 1'b0; cpu_addr = 18'h0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 5) cpu_req = 1'b0;
         if (cpu_ack) begin
            nAck++;
            if (nAck == 1) firstAck = c; else if (nAck == 2) secondAck = c;
            compared++; if (cpu_rdata !== refMem[0]) begin mismatched++; $display("[TB] FAIL b2b_rdata: got %h want %h", cpu_rdata, refMem[0]); end
         end
      end
      cpu_req = 1'b0;
      lastRd = refMem[0];
      compared++; if (nAck !== 2) begin mismatched++; $display("[TB] FAIL b2b_ack_count: got %0d want 2", nAck); end
      compared++; if (firstAck !== 2 || secondAck !== 5) begin mismatched++; $display("[TB] FAIL b2b_ack_cycles: got %0d,%0d want 2,5", firstAck, secondAck); end
   endtask

   // Reset is pulsed between clock edges while the merged write is on the
   // port. The write must be abandoned and the port must accept a request on
   // the first edge after reset is released.
   task automatic test_reset_rmw();
      int ac, wc, wy, ena; logic e; logic [31:0] rd, wd, x, d; logic [15:0] af, ar;
      x = $urandom;
      d = {24'h0, ~x[15:8]};
      preload(5, x);
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd0; cpu_signed = 1'b0;
      cpu_addr = 18'd21; cpu_wdata = d;
      @(negedge clk);
      cpu_req = 1'b0;
      @(negedge clk);
      compared++; if (mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL rmw_we_before_reset: got %b want 1", mem_we); end
      #1 rst_n = 1'b0;
      #1;
      compared++; if (mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL rmw_we_async_drop: got %b want 0", mem_we); end
      compared++; if (cpu_busy !== 1'b0 || cpu_ack !== 1'b0 || mem_a !== 16'h0 || mem_wd !== 32'h0) begin mismatched++; $display("[TB] FAIL rmw_reset_idle: got busy %b ack %b a %h wd %h want 0", cpu_busy, cpu_ack, mem_a, mem_wd); end
      compared++; if (cpu_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL rmw_reset_rdata: got %h want 0", cpu_rdata); end
      #1 rst_n = 1'b1;
      issue(0, 0, 2'd2, 0, 18'd20, 32'h0, ac, e, rd, wc, wy, wd, af, ar, ena);
      compared++; if (ac !== 2) begin mismatched++; $display("[TB] FAIL post_reset_accept: got ack cycle %0d want 2", ac); end
      compared++; if (rd !== x || dmem[5] !== x) begin mismatched++; $display("[TB] FAIL rmw_mem_unchanged: got %h/%h want %h", rd, dmem[5], x); end
   endtask

   // Runaway guard. Every wait above is cycle-bounded; this only catches a
   // bench bug.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Test sequence.
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_rmw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
